// File: rtl/washer_pkg.sv
// Washer controller shared types: state encoding, program codes and per-phase actuator mapping.
// Pure combinational helpers with no latency.
package washer_pkg;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FILL      = 3'd1,
      S_SOAP_WAIT = 3'd2,
      S_WASH      = 3'd3,
      S_DRAIN     = 3'd4,
      S_RINSE     = 3'd5,
      S_SPIN      = 3'd6,
      S_DONE      = 3'd7
   } state_e;

   localparam logic [1:0] PROG_COLD_WASH = 2'd0;
   localparam logic [1:0] PROG_HOT_WASH  = 2'd1;
   localparam logic [1:0] PROG_RINSE_DRY = 2'd2;
   localparam logic [1:0] PROG_DRY_ONLY  = 2'd3;

   typedef struct packed {
      logic cold;
      logic hot;
      logic drain;
      logic motor;
   } act_t;

   // SOAP_WAIT sits inside the running range so door/pause freezes apply to it too.
   function automatic logic is_run(state_e s);
      return (s >= S_FILL) && (s <= S_SPIN);
   endfunction

   function automatic state_e first_phase(logic [1:0] prog);
      case (prog)
         PROG_COLD_WASH, PROG_HOT_WASH: return S_FILL;
         PROG_RINSE_DRY:                return S_RINSE;
         default:                       return S_SPIN;
      endcase
   endfunction

   function automatic state_e next_phase(state_e s);
      case (s)
         S_FILL, S_SOAP_WAIT: return S_WASH;
         S_WASH:              return S_DRAIN;
         S_DRAIN:             return S_RINSE;
         S_RINSE:             return S_SPIN;
         S_SPIN:              return S_DONE;
         default:             return S_IDLE;
      endcase
   endfunction

   function automatic act_t phase_act(state_e s, logic [1:0] prog);
      act_t a;
      a = '0;
      case (s)
         S_FILL: begin
            a.cold = (prog == PROG_COLD_WASH);
            a.hot  = (prog == PROG_HOT_WASH);
         end
         S_WASH:  a.motor = 1'b1;
         S_DRAIN: a.drain = 1'b1;
         S_RINSE: begin
            a.cold  = 1'b1;
            a.motor = 1'b1;
         end
         S_SPIN: begin
            a.drain = 1'b1;
            a.motor = 1'b1;
         end
         default: a = '0;
      endcase
      return a;
   endfunction

endpackage

// File: rtl/washer_ctrl_param_if.sv
// Washer controller control/status bundle; master drives user inputs, slave is the controller.
interface washer_ctrl_param_if #(parameter int TIMER_W = 8);
   logic               power;
   logic [2:0]         program_selection;
   logic               start;
   logic               doorclosed;
   logic               soap;
   logic               pause;
   logic               valve_in_cold;
   logic               valve_in_hot;
   logic               valve_out;
   logic               motor;
   logic [TIMER_W-1:0] timer_display;
   logic               program_done;
   logic               program_error;
   logic               soap_warning;
   logic               door_warning;

   modport master (
      output power, program_selection, start, doorclosed, soap, pause,
      input  valve_in_cold, valve_in_hot, valve_out, motor, timer_display,
      input  program_done, program_error, soap_warning, door_warning
   );

   modport slave (
      input  power, program_selection, start, doorclosed, soap, pause,
      output valve_in_cold, valve_in_hot, valve_out, motor, timer_display,
      output program_done, program_error, soap_warning, door_warning
   );
endinterface

// File: rtl/washer_phase_timer.sv
// Loadable down-counter for remaining phase cycles; load wins over enable.
// Count holds at 1 rather than wrapping; o_last flags the final active cycle.
module washer_phase_timer #(
   parameter int TIMER_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_load,
   input  logic [TIMER_W-1:0] i_load_val,
   input  logic               i_en,
   output logic [TIMER_W-1:0] o_value,
   output logic               o_last
);

   logic [TIMER_W-1:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_en && (r_count > TIMER_W'(1))) begin
         r_count <= r_count - TIMER_W'(1);
      end
   end

   assign o_value = r_count;
   assign o_last  = (r_count == TIMER_W'(1));

endmodule

// File: rtl/washer_ctrl_param.sv
// Washer program sequencer; outputs decode from registered state, door/pause gate actuators in the same cycle.
// Optional WASHER_PAUSE_EN makes the pause input freeze a running phase; otherwise pause is ignored.
module washer_ctrl_param
   import washer_pkg::*;
#(
   parameter int TIMER_W = 8,
   parameter int T_FILL  = 20,
   parameter int T_WASH  = 40,
   parameter int T_DRAIN = 10,
   parameter int T_RINSE = 30,
   parameter int T_SPIN  = 25
) (
   input logic                clk,
   input logic                rst,
   washer_ctrl_param_if.slave bus
);

   state_e             r_state;
   state_e             w_state_nxt;
   logic [1:0]         r_prog;
   logic [1:0]         w_prog_nxt;
   logic               r_err;
   logic               w_err_nxt;
   logic               w_load;
   logic               w_en;
   logic [TIMER_W-1:0] w_load_val;
   logic [TIMER_W-1:0] w_timer;
   logic               w_last;
   logic               w_door_open;
   logic               w_paused;
   logic               w_hold;
   logic               w_run;
   act_t               w_act;

   function automatic logic [TIMER_W-1:0] phase_len(state_e s);
      case (s)
         S_FILL:              return TIMER_W'(T_FILL);
         S_WASH, S_SOAP_WAIT: return TIMER_W'(T_WASH);
         S_DRAIN:             return TIMER_W'(T_DRAIN);
         S_RINSE:             return TIMER_W'(T_RINSE);
         S_SPIN:              return TIMER_W'(T_SPIN);
         default:             return '0;
      endcase
   endfunction

   assign w_door_open = !bus.doorclosed;
`ifdef WASHER_PAUSE_EN
   assign w_paused = bus.pause;
`else
   assign w_paused = 1'b0;
`endif
   assign w_hold = w_door_open || w_paused;
   assign w_run  = is_run(r_state);

   washer_phase_timer #(.TIMER_W(TIMER_W)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .i_en       (w_en),
      .o_value    (w_timer),
      .o_last     (w_last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_prog  <= PROG_COLD_WASH;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_prog  <= w_prog_nxt;
         r_err   <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_prog_nxt  = r_prog;
      w_err_nxt   = 1'b0;
      w_load      = 1'b0;
      w_load_val  = '0;
      w_en        = 1'b0;
      if (!bus.power) begin
         w_state_nxt = S_IDLE;
         w_load      = 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  if (bus.program_selection[2]) begin
                     w_err_nxt = 1'b1;
                  end else if (bus.doorclosed) begin
                     w_prog_nxt  = bus.program_selection[1:0];
                     w_state_nxt = first_phase(bus.program_selection[1:0]);
                     w_load      = 1'b1;
                     w_load_val  = phase_len(w_state_nxt);
                  end
               end
            end
            // Timer was preloaded with T_WASH on entry, so WASH starts without a reload.
            S_SOAP_WAIT: begin
               if (!w_hold && bus.soap) begin
                  w_state_nxt = S_WASH;
               end
            end
            S_FILL, S_WASH, S_DRAIN, S_RINSE, S_SPIN: begin
               if (!w_hold) begin
                  w_en = 1'b1;
                  if (w_last) begin
                     w_state_nxt = (r_state == S_FILL && !bus.soap) ? S_SOAP_WAIT
                                                                    : next_phase(r_state);
                     w_load      = 1'b1;
                     w_load_val  = phase_len(w_state_nxt);
                  end
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   assign w_act = (w_run && !w_hold) ? phase_act(r_state, r_prog) : act_t'('0);

   assign bus.valve_in_cold = w_act.cold;
   assign bus.valve_in_hot  = w_act.hot;
   assign bus.valve_out     = w_act.drain;
   assign bus.motor         = w_act.motor;
   assign bus.timer_display = w_run ? w_timer : '0;
   assign bus.program_done  = (r_state == S_DONE);
   assign bus.program_error = r_err;
   assign bus.soap_warning  = (r_state == S_SOAP_WAIT);
   assign bus.door_warning  = w_run && w_door_open;

endmodule
